// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Fetch stage sitting behind the PC register. Issues one word read at a time
//   to instruction memory, buffers returned instructions (with their PC and a
//   misalignment fault flag) in a DEPTH-entry FIFO and hands them to decode.
//
// Ports
//   CLK, RESET                 clock, asynchronous active-high reset
//   pc_in / pc_advance         current PC in; PC consumed this cycle out
//   redirect                   flush queue and any in-flight fetch
//   imem_req_valid/ready/addr  memory read request (addr = pc_in)
//   imem_resp_valid/data       memory read data, one-cycle pulse
//   inst_valid/ready           queue head handshake to decode
//   inst_data/pc/fault         queue head contents (data is 0 on fault)
module inst_fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              redirect,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic              fault;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] fl_pc;      // PC of the fetch currently in flight

  logic             pop, push, accept, fault_push, resp_push;
  logic             aligned, can_issue, credit;
  logic [CNT_W-1:0] cnt_after_pop, occ;
  entry_t           push_entry, head;

  assign head       = mem[rd_ptr];
  assign inst_valid = (count != '0);
  assign inst_fault = head.fault;
  assign inst_pc    = head.pc;
  assign inst_data  = head.data;

  assign pop = inst_valid && inst_ready;

  // An in-flight fetch already owns a slot; the new request needs one more,
  // so occupancy-after-pop plus in-flight must leave room.
  assign cnt_after_pop = count - CNT_W'(pop);
  assign occ           = cnt_after_pop + CNT_W'(state == WAIT);
  assign credit        = occ < CNT_W'(DEPTH);

  assign aligned   = (pc_in[1:0] == 2'b00);
  // In WAIT a new request may go out in the cycle the response lands, which
  // sustains one instruction per cycle at single-cycle memory latency.
  assign can_issue = (state == IDLE) || ((state == WAIT) && imem_resp_valid);

  assign imem_req_valid = !RESET && !redirect && credit && aligned && can_issue;
  assign imem_req_addr  = RESET ? '0 : pc_in;
  assign accept         = imem_req_valid && imem_req_ready;

  // Misaligned PC never reaches memory; it becomes a fault entry directly.
  assign fault_push = !RESET && !redirect && credit && !aligned && (state == IDLE);
  assign resp_push  = !redirect && (state == WAIT) && imem_resp_valid;
  assign push       = fault_push || resp_push;
  assign pc_advance = accept || fault_push;

  always_comb begin
    push_entry = '0;
    if (fault_push) begin
      push_entry.fault = 1'b1;
      push_entry.pc    = pc_in;
    end else begin
      push_entry.pc    = fl_pc;
      push_entry.data  = imem_resp_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fl_pc  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // An outstanding fetch must have its response swallowed. A response
      // landing in DRAIN together with a redirect is that very response, so
      // DRAIN is left rather than waiting for one that never comes.
      if ((state == WAIT || state == DRAIN) && !imem_resp_valid) state <= DRAIN;
      else                                                        state <= IDLE;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        IDLE: if (accept) begin
          state <= WAIT;
          fl_pc <= pc_in;
        end
        WAIT: if (imem_resp_valid) begin
          if (accept) fl_pc <= pc_in;
          else        state <= IDLE;
        end
        DRAIN: if (imem_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
